// File: rtl/handshake_pkg.sv
// Shared constants for the four-phase handshake initiator: state encodings,
// default parameter values and counter widths.
package handshake_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 16;
    localparam int CNT_W       = 8;
    localparam int WAIT_W      = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_REQ_HI = 3'd1;
    localparam state_t ST_REQ_LO = 3'd2;
    localparam state_t ST_DONE   = 3'd3;
    localparam state_t ST_ERR    = 3'd4;

endpackage

// File: rtl/hs_timeout_cnt.sv
// Per-phase wait counter: clears on phase entry, counts cycles the awaited ack
// level is missing and flags the last permitted wait cycle.
module hs_timeout_cnt
    import handshake_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [WAIT_W-1:0] count;

    assign tc = (count == WAIT_W'(LIMIT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !tc) begin
            count <= count + WAIT_W'(1);
        end
    end

endmodule

// File: rtl/handshake_initiator.sv
// Four-phase request/acknowledge initiator with per-phase timeout, a completed
// transfer counter and single-cycle done/err status pulses.
module handshake_initiator
    import handshake_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              req,
    output logic [DATA_W-1:0] dout,
    input  logic              ack
);

    state_t state;
    state_t next_state;
    logic   cnt_clear;
    logic   cnt_en;
    logic   wait_tc;

    hs_timeout_cnt #(
        .LIMIT (TIMEOUT)
    ) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .tc     (wait_tc)
    );

    // An arriving ack is tested before the terminal count, so a response on
    // the last permitted cycle still completes the phase.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        next_state = state;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !ack) begin
                    next_state = ST_REQ_HI;
                    cnt_clear  = 1'b1;
                end
            end
            ST_REQ_HI: begin
                if (ack) begin
                    next_state = ST_REQ_LO;
                    cnt_clear  = 1'b1;
                end else if (wait_tc) begin
                    next_state = ST_ERR;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_REQ_LO: begin
                if (!ack) begin
                    next_state = ST_DONE;
                end else if (wait_tc) begin
                    next_state = ST_ERR;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            ST_ERR:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            req      <= 1'b0;
            dout     <= '0;
            xfer_cnt <= '0;
        end else begin
            state <= next_state;
            req   <= (next_state == ST_REQ_HI);
            if (state == ST_IDLE && next_state == ST_REQ_HI) begin
                dout <= din;
            end
            // Counting on entry makes the new total visible alongside done.
            if (next_state == ST_DONE) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign err  = (state == ST_ERR);

endmodule

// File: tb/tb_handshake_initiator.sv
// Scoreboard bench for handshake_initiator with a delay-configurable responder.
module tb_handshake_initiator;
    import handshake_pkg::*;

    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b1;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          ack = 1'b0;
    logic [DW-1:0] din = '0;
    logic          busy, done, err, req;
    logic [7:0]    xfer_cnt;
    logic [DW-1:0] dout;

    handshake_initiator #(
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .xfer_cnt (xfer_cnt),
        .req      (req),
        .dout     (dout),
        .ack      (ack)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        logic [7:0] cnt;
        int         at;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_cnt = 8'd0;

    // Responder: raises ack hi_delay negedges after seeing req, drops it
    // lo_delay negedges after req falls; hi_never models a dead responder.
    bit resp_en  = 1'b1;
    bit hi_never = 1'b0;
    int hi_delay = 0;
    int lo_delay = 0;
    int rcnt     = 0;

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            ack  = 1'b0;
            rcnt = 0;
        end else if (resp_en) begin
            if (req && !ack) begin
                if (!hi_never) begin
                    if (rcnt >= hi_delay) begin
                        ack  = 1'b1;
                        rcnt = 0;
                    end else begin
                        rcnt++;
                    end
                end
            end else if (!req && ack) begin
                if (rcnt >= lo_delay) begin
                    ack  = 1'b0;
                    rcnt = 0;
                end else begin
                    rcnt++;
                end
            end else begin
                rcnt = 0;
            end
        end
    end

    // Monitor: pops one expectation per done/err pulse.
    int   done_seen = 0;
    int   req_rises = 0;
    logic req_q = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        if (rst) begin
            if (req && !req_q) req_rises++;
            req_q = req;
            if (done && err) check("done_err_overlap", 1, 0);
            if (done || err) begin
                if (done) done_seen++;
                check("pulse_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("pulse_kind_err", err, e.is_err);
                    check("pulse_dout", dout, e.data);
                    check("pulse_xfer_cnt", xfer_cnt, e.cnt);
                    check("pulse_cycle", cyc, e.at);
                    if (err) check("req_low_in_err", req, 0);
                end
            end
        end else begin
            req_q = 1'b0;
        end
    end

    task automatic launch(input logic [7:0] data, input int hi, input int lo,
                          input bit never, input bit expect_pulse);
        @(negedge clk);
        hi_delay = hi;
        lo_delay = lo;
        hi_never = never;
        start    = 1'b1;
        din      = data;
        if (expect_pulse) begin
            if (never || hi >= TO) begin
                sb.push_back('{1'b1, data, exp_cnt, cyc + TO + 1});
            end else begin
                exp_cnt++;
                sb.push_back('{1'b0, data, exp_cnt, cyc + hi + lo + 3});
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("req_after_start", req, 1);
        check("dout_latched", dout, data);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", busy, 0);
    endtask

    initial begin
        int r0;
        int d0;
        int n;

        // Reset values while rst is held low.
        #12;
        check("rst_busy", busy, 0);
        check("rst_req", req, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_xfer_cnt", xfer_cnt, 0);
        check("rst_dout", dout, 0);
        #3 rst = 1'b1;

        // Nominal transfer.
        launch(8'hA5, 2, 0, 0, 1);
        wait_idle(40);
        @(negedge clk); #1;
        check("nominal_busy_after", busy, 0);
        check("nominal_cnt", xfer_cnt, 1);
        check("nominal_dout_hold", dout, 8'hA5);

        // Dead responder: abort after TO cycles in REQ_HI.
        launch(8'h3C, 0, 0, 1, 1);
        wait_idle(40);
        hi_never = 1'b0;
        @(negedge clk); #1;
        check("timeout_cnt_unchanged", xfer_cnt, 1);
        check("timeout_dout_hold", dout, 8'h3C);

        // Ack on the last permitted wait cycle completes; one later aborts.
        launch(8'hC3, TO - 1, 0, 0, 1);
        wait_idle(40);
        launch(8'h81, TO, 0, 0, 1);
        wait_idle(40);
        @(negedge clk); #1;
        check("boundary_cnt", xfer_cnt, 2);

        // Start pulsed while in REQ_LO must be ignored.
        @(negedge clk); #1;
        r0 = req_rises;
        launch(8'h11, 1, 3, 0, 1);
        n = 0;
        while (!(req == 1'b0 && ack == 1'b1 && busy) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("reached_req_lo", n < 20, 1);
        start = 1'b1;
        din   = 8'h99;
        @(negedge clk);
        start = 1'b0;
        wait_idle(40);
        repeat (3) @(negedge clk);
        #1;
        check("req_lo_single_req", req_rises - r0, 1);
        check("req_lo_dout", dout, 8'h11);
        check("req_lo_cnt", xfer_cnt, 3);

        // Start while ack is stuck high in IDLE must be ignored.
        @(negedge clk);
        resp_en = 1'b0;
        ack     = 1'b1;
        start   = 1'b1;
        din     = 8'h77;
        r0      = req_rises;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("stuck_ack_busy", busy, 0);
            check("stuck_ack_req", req, 0);
        end
        check("stuck_ack_dout", dout, 8'h11);
        check("stuck_ack_no_req", req_rises - r0, 0);
        start   = 1'b0;
        ack     = 1'b0;
        rcnt    = 0;
        resp_en = 1'b1;

        // Asynchronous reset in the middle of REQ_HI.
        launch(8'h5A, 0, 0, 1, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_req", req, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cnt", xfer_cnt, 0);
        check("midrst_dout", dout, 0);
        exp_cnt  = 8'd0;
        hi_never = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_idle", busy, 0);
        check("midrst_sb_empty", sb.size(), 0);

        // 256 back-to-back transfers wrap the counter to zero.
        d0 = done_seen;
        for (int i = 0; i < 256; i++) begin
            launch(8'(i), 0, 0, 0, 1);
            wait_idle(20);
        end
        @(negedge clk); #1;
        check("wrap_done_count", done_seen - d0, 256);
        check("wrap_cnt", xfer_cnt, 0);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
